record_access_scheduler: RTL

Arbitrates and sequences all access to `RecordStorageManager` for two requesters:
- **Writer:** game-end logic appending a new `PlayRecord`.
- **Reader:** history/leaderboard display fetching records by recency.

The block keeps the storage as a ring buffer, translates logical "n-th newest" indices to physical record ids, and owns the storage's `read_record_id`, `write_record_id` and `new_record_data` inputs. No other block drives them.

---
 rtl/record_access_scheduler_pkg.sv | 26 ++
 rtl/rec_ring_addr.sv | 27 ++
 rtl/record_access_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/record_access_scheduler_pkg.sv
// Shared types for the play-record access scheduler: record layout, storage depth
// default, FSM state encoding and grant owner.
package record_access_scheduler_pkg;

  localparam int PLAY_RECS_MAX = 8;

  typedef struct packed {
    logic [15:0] score;
    logic [7:0]  level;
    logic [7:0]  lines;
  } play_record_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic {
    GRANT_W,
    GRANT_R
  } grant_t;

endpackage

// File: rtl/rec_ring_addr.sv
// Maps (head, logical index) to a physical ring id in 1..cap. A negative index
// walks forward, so index = -1 yields the next write slot.
module rec_ring_addr (
  input  logic [7:0]        head,
  input  logic signed [8:0] index,
  input  logic [7:0]        cap,
  output logic [7:0]        phys
);

  logic signed [10:0] raw;
  logic signed [10:0] wrapped;
  logic signed [10:0] cap_s;

  always_comb begin
    cap_s   = $signed({3'b000, cap});
    raw     = $signed({3'b000, head}) - $signed({{2{index[8]}}, index});
    wrapped = raw;
    // Id 0 is reserved for "no operation", so the valid window is 1..cap.
    if (raw < 11'sd1) begin
      wrapped = raw + cap_s;
    end else if (raw > cap_s) begin
      wrapped = raw - cap_s;
    end
    phys = 8'(wrapped);
  end

endmodule

// File: rtl/record_access_scheduler.sv
// Arbitrates a writer (append newest record) and a reader (fetch n-th newest)
// onto a ring-buffered record storage with a one-cycle registered read port.
module record_access_scheduler
  import record_access_scheduler_pkg::*;
#(
  parameter int RECS_MAX    = PLAY_RECS_MAX,
  parameter int PRELOAD_CNT = 3
) (
  input  logic         clk,
  input  logic         sys_rst,
  input  logic         wr_req,
  input  play_record_t wr_data,
  output logic         wr_ack,
  input  logic         rd_req,
  input  logic [7:0]   rd_index,
  output logic         rd_ack,
  output logic         rd_hit,
  output play_record_t rd_data,
  output logic [7:0]   rec_count,
  output logic         busy,
  output logic [7:0]   mem_read_id,
  output logic [7:0]   mem_write_id,
  output play_record_t mem_new_data,
  input  play_record_t mem_rd_data,
  output state_t       dbg_state
);

  localparam logic [7:0] CAP     = 8'(RECS_MAX - 1);
  localparam logic [7:0] PRELOAD = 8'(PRELOAD_CNT);

  // Handshake: a requester raises req with stable data and holds it until its
  // one-cycle ack; it drops req in the following cycle. A req seen high in IDLE
  // is always treated as a fresh request.

  state_t       state;
  grant_t       last_grant;
  logic [7:0]   head;
  logic [7:0]   count;
  logic [7:0]   phys;
  play_record_t lat_data;
  logic [7:0]   rd_phys;
  logic [7:0]   next_wr_id;
  logic         grant_w;

  rec_ring_addr u_rd_addr (
    .head  (head),
    .index ({1'b0, rd_index}),
    .cap   (CAP),
    .phys  (rd_phys)
  );

  rec_ring_addr u_wr_addr (
    .head  (head),
    .index (9'h1FF),
    .cap   (CAP),
    .phys  (next_wr_id)
  );

  // Round-robin only matters when both ask at once.
  assign grant_w = wr_req && (!rd_req || (last_grant == GRANT_R));

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_R;
      head       <= PRELOAD;
      count      <= PRELOAD;
      phys       <= '0;
      lat_data   <= '0;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_hit     <= 1'b0;
      rd_data    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_w) begin
            last_grant <= GRANT_W;
            lat_data   <= wr_data;
            wr_ack     <= 1'b1;
            state      <= ST_WRITE;
          end else if (rd_req) begin
            last_grant <= GRANT_R;
            if (rd_index >= count) begin
              rd_hit  <= 1'b0;
              rd_data <= '0;
              rd_ack  <= 1'b1;
              state   <= ST_RESP;
            end else begin
              phys  <= rd_phys;
              state <= ST_RD_ISSUE;
            end
          end
        end
        ST_WRITE: begin
          head   <= next_wr_id;
          count  <= (count >= CAP) ? CAP : count + 8'd1;
          wr_ack <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_RD_ISSUE: begin
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          rd_data <= mem_rd_data;
          rd_hit  <= 1'b1;
          rd_ack  <= 1'b1;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          rd_ack <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // head is stable throughout WRITE, so the decoded write id matches the slot committed.
  assign mem_write_id = (state == ST_WRITE)    ? next_wr_id : 8'd0;
  assign mem_read_id  = (state == ST_RD_ISSUE) ? phys       : 8'd0;
  assign mem_new_data = lat_data;
  assign rec_count    = count;
  assign busy         = (state != ST_IDLE);
  assign dbg_state    = state;

endmodule
